// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU constants: FSM state codes and radix-4 Booth op codes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] BOOTH_ZERO = 3'd0;
  localparam logic [2:0] BOOTH_PM   = 3'd1;
  localparam logic [2:0] BOOTH_P2M  = 3'd2;
  localparam logic [2:0] BOOTH_MM   = 3'd3;
  localparam logic [2:0] BOOTH_M2M  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/booth_recoder.sv
// ============================================================================
// Module   : booth_recoder
// Purpose  : Radix-4 Booth recoding of a {Q[i+1],Q[i],Q[i-1]} window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_recoder
  import alu_pkg::*;
(
  input  logic [2:0] window,
  output logic [2:0] op
);

  always_comb begin
    op = BOOTH_ZERO;
    case (window)
      3'b001, 3'b010: op = BOOTH_PM;
      3'b011:         op = BOOTH_P2M;
      3'b100:         op = BOOTH_M2M;
      3'b101, 3'b110: op = BOOTH_MM;
      default:        op = BOOTH_ZERO;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
// ============================================================================
// Module   : booth_seq_multiplier
// Purpose  : Sequential signed WIDTHxWIDTH multiplier, one Booth bit pair/clk.
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITER = WIDTH / 2;
  localparam int AW   = WIDTH + 2;
  localparam int CW   = $clog2(ITER + 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [2:0]       booth_op;
  logic [AW-1:0]    term;
  logic [AW-1:0]    sum;
  logic             last_iter;
  logic             accept;

  booth_recoder u_recoder (
    .window ({q_q[1:0], qm1_q}),
    .op     (booth_op)
  );

  assign last_iter = (count_q == CW'(ITER - 1));
  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The two guard bits on the accumulator keep -2M exact for the most-negative M.
  always_comb begin
    term = '0;
    case (booth_op)
      BOOTH_PM:  term = mcand_q;
      BOOTH_P2M: term = mcand_q << 1;
      BOOTH_MM:  term = -mcand_q;
      BOOTH_M2M: term = -(mcand_q << 1);
      default:   term = '0;
    endcase
    sum = acc_q + term;
  end

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (accept) begin
      mcand_d = {{2{multiplicand[WIDTH-1]}}, multiplicand};
      q_d     = multiplier;
      qm1_d   = 1'b0;
      acc_d   = '0;
      count_d = '0;
    end else if (state_q == S_RUN) begin
      acc_d   = {{2{sum[AW-1]}}, sum[AW-1:2]};
      q_d     = {sum[1:0], q_q[WIDTH-1:2]};
      qm1_d   = q_q[1];
      count_d = count_q + CW'(1);
      // After the final shift the exact product sits in the low 2*WIDTH bits.
      if (last_iter) begin
        hi_d = acc_d[WIDTH-1:0];
        lo_d = q_d;
      end
    end
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
// ============================================================================
// Module   : tb_booth_seq_multiplier
// Purpose  : Directed and random checks of booth_seq_multiplier vs. 64-bit math.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_booth_seq_multiplier;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_prod = 64'd0;
  int          n;

  booth_seq_multiplier #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q);
    longint a, b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return a * b;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after the accept edge; returns edges taken until done is seen.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
      if (done !== 1'b1) begin
        check("busy_run", {63'd0, busy}, 64'd1);
        check("hold_hilo", {hi, lo}, last_prod);
      end
    end while (done !== 1'b1 && edges < 40);
  endtask

  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input string tag);
    int          edges;
    logic [63:0] exp;
    exp          = ref_prod(m, q);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    wait_done(edges);
    check({tag, "_lat"}, 64'(edges), 64'd16);
    check(tag, {hi, lo}, exp);
    last_prod = exp;
    tick();
    check({tag, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    clr          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    tick();

    run_op(32'd7, 32'hFFFF_FFFD, "m7_qm3");
    check("m7_qm3_const", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(32'h8000_0000, 32'h8000_0000, "minneg_sq");
    check("minneg_const", last_prod, 64'h4000_0000_0000_0000);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, "maxpos_sq");
    check("maxpos_const", last_prod, 64'h3FFF_FFFF_0000_0001);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "m1_sq");
    check("m1_const", last_prod, 64'd1);

    // Start while busy: second request must be ignored.
    multiplicand = 32'd5;
    multiplier   = 32'd6;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("busy_start_lat", 64'(n + 5), 64'd16);
    check("busy_start_prod", {hi, lo}, 64'd30);
    last_prod = 64'd30;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("busy_start_idle", {62'd0, busy, done}, 64'd0);
    end

    // Back-to-back with start held high.
    multiplicand = 32'd3;
    multiplier   = 32'd4;
    start        = 1'b1;
    tick();
    wait_done(n);
    check("b2b1_lat", 64'(n), 64'd16);
    check("b2b1_prod", {hi, lo}, 64'd12);
    last_prod    = 64'd12;
    multiplicand = 32'hFFFF_FFFE;
    multiplier   = 32'd10;
    tick();
    start = 1'b0;
    check("b2b_reaccept", {62'd0, busy, done}, 64'd2);
    wait_done(n);
    check("b2b2_lat", 64'(n), 64'd16);
    check("b2b2_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEC);
    last_prod = 64'hFFFF_FFFF_FFFF_FFEC;
    tick();

    // Asynchronous reset in the middle of a run.
    multiplicand = 32'd1234;
    multiplier   = 32'd5678;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    #2 clr = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    last_prod = 64'd0;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("arst_no_done", {62'd0, busy, done}, 64'd0);
    end
    run_op(32'hFFFF_D000, 32'd77, "after_rst");

    for (int i = 0; i < 1500; i++) begin
      run_op(pick_operand(), pick_operand(), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
